// File: rtl/conv_pkg.sv
// Shared state type and elaboration-time helpers for the conv_window_mac engine.
package conv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int width;
    int rem;
    width = 0;
    rem   = value - 1;
    while (rem > 0) begin
      width = width + 1;
      rem   = rem >> 1;
    end
    return width;
  endfunction

  // Worst-case window sum width: signed product plus growth over KSIZE^2 terms.
  function automatic int acc_width(input int data_w, input int coef_w, input int ksize);
    return data_w + coef_w + 1 + clog2(ksize * ksize);
  endfunction

  function automatic logic [63:0] abs_val(input logic signed [63:0] value);
    return (value < 0) ? 64'(-value) : 64'(value);
  endfunction

  function automatic logic [63:0] sat_abs(input logic signed [63:0] value, input int data_w);
    logic [63:0] limit;
    logic [63:0] magnitude;
    limit     = (64'd1 << data_w) - 64'd1;
    magnitude = abs_val(value);
    return (magnitude > limit) ? limit : magnitude;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One accumulation lane: unsigned pixel times signed coefficient, summed into a
// full-precision signed accumulator with clear and enable.
module mac_lane #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] pix,
  input  logic [COEF_W-1:0] coef,
  output logic [ACC_W-1:0]  sum
);

  localparam int PROD_W = DATA_W + COEF_W + 1;

  logic signed [DATA_W:0]   pix_s;
  logic signed [COEF_W-1:0] coef_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum_d;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;

  // The leading zero keeps the pixel non-negative once treated as signed.
  always_comb begin
    pix_s  = {1'b0, pix};
    coef_s = coef;
    prod   = PROD_W'(pix_s) * PROD_W'(coef_s);
    sum_d  = acc_q + ACC_W'(prod);
    acc_d  = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign sum = sum_d;

endmodule

// File: rtl/conv_window_mac.sv
// Multi-channel KSIZE x KSIZE window multiply-accumulate engine.
// Optional L1 gradient magnitude output enabled by defining CONV_MAG_EN.
module conv_window_mac import conv_pkg::*; #(
  parameter int  KSIZE    = 5,
  parameter int  DATA_W   = 8,
  parameter int  COEF_W   = 8,
  parameter int  CHANNELS = 2,
  localparam int ACC_W    = acc_width(DATA_W, COEF_W, KSIZE)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [KSIZE*KSIZE*DATA_W-1:0]         window,
  input  logic [CHANNELS*KSIZE*KSIZE*COEF_W-1:0] kernels,
  output logic                                  busy,
  output logic                                  done,
  output logic [CHANNELS*ACC_W-1:0]             result,
  output logic [CHANNELS*DATA_W-1:0]            pix
`ifdef CONV_MAG_EN
  ,
  output logic [DATA_W-1:0]                     mag
`endif
);

  localparam int NELEM = KSIZE * KSIZE;
  localparam int IDX_W = clog2(NELEM);
  localparam int WIN_W = NELEM * DATA_W;
  localparam int KER_W = CHANNELS * NELEM * COEF_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NELEM - 1);

  if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
    $error("conv_window_mac: KSIZE must be 3 or 5");
  end
`ifdef CONV_MAG_EN
  if (CHANNELS < 2) begin : g_bad_channels
    $error("conv_window_mac: CONV_MAG_EN needs CHANNELS >= 2");
  end
`endif

  state_e                    state_d, state_q;
  logic [IDX_W-1:0]          idx_d, idx_q;
  logic [WIN_W-1:0]          win_d, win_q;
  logic [KER_W-1:0]          ker_d, ker_q;
  logic                      busy_d, busy_q;
  logic                      done_d, done_q;
  logic [CHANNELS*ACC_W-1:0] result_d, result_q;
  logic [CHANNELS*DATA_W-1:0] pix_d, pix_q;
  logic                      clr, en, accept;
  logic [DATA_W-1:0]         cur_pix;
  logic [ACC_W-1:0]          lane_sum [CHANNELS];
`ifdef CONV_MAG_EN
  logic [DATA_W-1:0]         mag_d, mag_q;
`endif

  assign cur_pix = win_q[int'(idx_q)*DATA_W +: DATA_W];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    mac_lane #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .en   (en),
      .pix  (cur_pix),
      .coef (ker_q[(c*NELEM + int'(idx_q))*COEF_W +: COEF_W]),
      .sum  (lane_sum[c])
    );
  end

  // NOTE: every signal gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    win_d    = win_q;
    ker_d    = ker_q;
    done_d   = 1'b0;
    result_d = result_q;
    pix_d    = pix_q;
    clr      = 1'b0;
    en       = 1'b0;
    accept   = 1'b0;
`ifdef CONV_MAG_EN
    mag_d    = mag_q;
`endif

    unique case (state_q)
      IDLE: accept = start;
      RUN: begin
        en    = 1'b1;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
          idx_d   = '0;
          // The final element is still in flight, so outputs come from the lane sums.
          for (int c = 0; c < CHANNELS; c++) begin
            result_d[c*ACC_W +: ACC_W]   = lane_sum[c];
            pix_d[c*DATA_W +: DATA_W]    = DATA_W'(sat_abs(64'(signed'(lane_sum[c])), DATA_W));
          end
`ifdef CONV_MAG_EN
          mag_d = DATA_W'(sat_abs(abs_val(64'(signed'(lane_sum[0])))
                                  + abs_val(64'(signed'(lane_sum[1]))), DATA_W));
`endif
          // Taking the next window on the done edge keeps one window per KSIZE^2 clocks.
          accept = start;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      win_d   = window;
      ker_d   = kernels;
      idx_d   = '0;
      clr     = 1'b1;
      state_d = RUN;
    end

    busy_d = (state_d == RUN) && !done_d;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      pix_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      pix_q    <= pix_d;
    end
  end

  // NOTE: capture registers carry no reset; they are only read after an accept loads them.
  always_ff @(posedge clk) begin
    win_q <= win_d;
    ker_q <= ker_d;
  end

`ifdef CONV_MAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q <= '0;
    end else begin
      mag_q <= mag_d;
    end
  end

  assign mag = mag_q;
`endif

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign pix    = pix_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// Self-checking bench for conv_window_mac: cycle-level reference model plus
// directed windows with hand-computed sums, at KSIZE=5 and KSIZE=3.
module tb_conv_window_mac;

  localparam int NE  = 25;
  localparam int DW  = 8;
  localparam int CW  = 8;
  localparam int CH  = 2;
  localparam int AW  = 22;
  localparam int NE3 = 9;
  localparam int AW3 = 21;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start3 = 1'b0;
  logic [NE*DW-1:0]     window  = '0;
  logic [CH*NE*CW-1:0]  kernels = '0;
  logic [NE3*DW-1:0]    window3 = '0;
  logic [CH*NE3*CW-1:0] kernels3 = '0;

  logic              busy, done, busy3, done3;
  logic [CH*AW-1:0]  result;
  logic [CH*AW3-1:0] result3;
  logic [CH*DW-1:0]  pix, pix3;
`ifdef CONV_MAG_EN
  logic [DW-1:0]     mag, mag3;
`endif

  conv_window_mac dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .window  (window),
    .kernels (kernels),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .pix     (pix)
`ifdef CONV_MAG_EN
    ,
    .mag     (mag)
`endif
  );

  conv_window_mac #(.KSIZE(3)) dut3 (
    .clk     (clk),
    .rst     (rst),
    .start   (start3),
    .window  (window3),
    .kernels (kernels3),
    .busy    (busy3),
    .done    (done3),
    .result  (result3),
    .pix     (pix3)
`ifdef CONV_MAG_EN
    ,
    .mag     (mag3)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint res_ch(input int c);
    return longint'($signed(result[c*AW +: AW]));
  endfunction

  function automatic longint res3_ch(input int c);
    return longint'($signed(result3[c*AW3 +: AW3]));
  endfunction

  function automatic longint sat(input longint v);
    longint a;
    a = (v < 0) ? -v : v;
    return (a > 255) ? 255 : a;
  endfunction

  // Direct dot product of the presented window with one kernel.
  function automatic longint window_sum(input int c);
    longint s;
    longint px;
    logic signed [CW-1:0] kv;
    s = 0;
    for (int i = 0; i < NE; i++) begin
      px = longint'(window[i*DW +: DW]);
      kv = kernels[(c*NE + i)*CW +: CW];
      s  = s + px * longint'(kv);
    end
    return s;
  endfunction

  // Reference model: a job accepted at cycle N finishes at cycle N+25.
  int     cyc = 0;
  bit     m_valid = 1'b0;
  bit     pend = 1'b0;
  int     pend_cyc = 0;
  longint pend_res [CH];
  bit     e_done = 1'b0;
  bit     e_busy = 1'b0;
  longint e_res [CH];
  longint e_pix [CH];
  longint e_mag = 0;

  always @(posedge clk) begin : model
    bit done_now;
    cyc     = cyc + 1;
    m_valid = 1'b1;
    e_done  = 1'b0;
    if (rst) begin
      pend   = 1'b0;
      e_busy = 1'b0;
      e_mag  = 0;
      for (int c = 0; c < CH; c++) begin
        e_res[c] = 0;
        e_pix[c] = 0;
      end
    end else begin
      done_now = pend && (cyc == pend_cyc);
      if (done_now) begin
        e_done = 1'b1;
        pend   = 1'b0;
        for (int c = 0; c < CH; c++) begin
          e_res[c] = pend_res[c];
          e_pix[c] = sat(pend_res[c]);
        end
        e_mag = sat(sat(pend_res[0]) == 255 ? 255 :
                    ((pend_res[0] < 0 ? -pend_res[0] : pend_res[0]) +
                     (pend_res[1] < 0 ? -pend_res[1] : pend_res[1])));
      end
      if (start && !pend) begin
        pend     = 1'b1;
        pend_cyc = cyc + NE;
        for (int c = 0; c < CH; c++) pend_res[c] = window_sum(c);
      end
      e_busy = pend && !done_now;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc done", longint'(done), longint'(e_done));
      check("cyc busy", longint'(busy), longint'(e_busy));
      for (int c = 0; c < CH; c++) begin
        check("cyc result", res_ch(c), e_res[c]);
        check("cyc pix", longint'(pix[c*DW +: DW]), e_pix[c]);
      end
`ifdef CONV_MAG_EN
      check("cyc mag", longint'(mag), e_mag);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int pv, input int k0, input int k1);
    for (int i = 0; i < NE; i++) begin
      window[i*DW +: DW]           = DW'(pv);
      kernels[i*CW +: CW]          = CW'(k0);
      kernels[(NE + i)*CW +: CW]   = CW'(k1);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 60);
  endtask

  task automatic run_window(input string tag, input longint r0, input longint r1,
                            input longint p0, input longint p1);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check({tag, " latency"}, n, 25);
    check({tag, " result0"}, res_ch(0), r0);
    check({tag, " result1"}, res_ch(1), r1);
    check({tag, " pix0"}, longint'(pix[DW-1:0]), p0);
    check({tag, " pix1"}, longint'(pix[2*DW-1:DW]), p1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int extra;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("reset busy", longint'(busy), 0);
    check("reset done", longint'(done), 0);
    check("reset result0", res_ch(0), 0);
    check("reset pix", longint'(pix), 0);

    set_all(1, 1, 1);
    run_window("ones", 25, 25, 25, 25);
    tick();

    // Columns 3-4 bright; ch0 is a right-minus-left column kernel.
    set_all(0, 0, 0);
    for (int r = 0; r < 5; r++) begin
      window[(r*5 + 3)*DW +: DW] = 8'd255;
      window[(r*5 + 4)*DW +: DW] = 8'd255;
      kernels[(r*5 + 4)*CW +: CW] = 8'sd1;
      kernels[(r*5 + 0)*CW +: CW] = -8'sd1;
    end
    run_window("vedge", 1275, 0, 255, 0);
`ifdef CONV_MAG_EN
    check("vedge mag", longint'(mag), 255);
`endif
    tick();

    set_all(255, -128, -128);
    run_window("negext", -816000, -816000, 255, 255);
    tick();

    // A start pulse five edges into a run is dropped.
    set_all(1, 1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    set_all(2, 1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check("ignored latency", n, 20);
    check("ignored result0", res_ch(0), 25);
    extra = 0;
    repeat (40) begin
      tick();
      if (done) extra++;
    end
    check("ignored extra done", extra, 0);

    // Held start: second window is taken on the first done edge.
    set_all(1, 1, 1);
    start = 1'b1;
    tick();
    set_all(2, 1, 1);
    wait_done(n);
    check("b2b first latency", n, 25);
    check("b2b first result", res_ch(0), 25);
    start = 1'b0;
    wait_done(n);
    check("b2b gap", n, 25);
    check("b2b second result", res_ch(1), 50);
    repeat (3) tick();

    // Reset ten edges into a run aborts it without a done.
    set_all(3, 1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", longint'(busy), 0);
    check("abort done", longint'(done), 0);
    check("abort result0", res_ch(0), 0);
    check("abort pix", longint'(pix), 0);
    extra = 0;
    repeat (40) begin
      tick();
      if (done) extra++;
    end
    check("abort no done", extra, 0);
    set_all(1, 1, 1);
    run_window("after abort", 25, 25, 25, 25);

    // KSIZE=3 instance: window 1..9, ch0 all +1, ch1 all -1.
    for (int i = 0; i < NE3; i++) begin
      window3[i*DW +: DW]          = DW'(i + 1);
      kernels3[i*CW +: CW]         = 8'sd1;
      kernels3[(NE3 + i)*CW +: CW] = -8'sd1;
    end
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done3 && n < 30);
    check("k3 latency", n, 9);
    check("k3 result0", res3_ch(0), 45);
    check("k3 result1", res3_ch(1), -45);
    check("k3 pix0", longint'(pix3[DW-1:0]), 45);
    check("k3 pix1", longint'(pix3[2*DW-1:DW]), 45);
    tick();
    check("k3 done pulse", longint'(done3), 0);
    check("k3 idle", longint'(busy3), 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
